// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between instruction fetch and data access
// Ports:
//   CLK, nRST               clock (rising edge), asynchronous active-low reset
//   iREN, iaddr             instruction read request and word address
//   dREN, dWEN, daddr       data read/write request and address
//   dstore                  data write value
//   ram_ready, ramload      RAM completion strobe and read data
//   ramREN, ramWEN          RAM read/write strobes
//   ramaddr, ramstore       RAM address and write data
//   iready, iload           instruction completion pulse and fetched word
//   dready, dload           data completion pulse and read word
//   timeout_err             one-cycle pulse when the watchdog aborts an access
module mem_arbiter #(
    parameter int DSTREAK_MAX = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic        ram_ready,
    input  logic [31:0] ramload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        iready,
    output logic        dready,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;
    localparam logic [3:0] SMAX = 4'(DSTREAK_MAX);
    localparam logic [7:0] WLAST = 8'(TIMEOUT - 1);
    state_t state, next;
    logic [3:0] streak, streak_n;
    logic [7:0] wdog;
    logic [31:0] iload_q, dload_q;
    logic req, done, tmo;
    always_comb begin
        // req is the granted requester still asking; dropping it withdraws the access
        req = (state == IACC) ? iREN : (state == DACC) ? (dREN | dWEN) : 1'b0;
        done = req & ram_ready;
        tmo = req & ~ram_ready & (wdog == WLAST);
        ramREN = (state == IACC) ? iREN : (state == DACC) ? (dREN & ~dWEN) : 1'b0;
        ramWEN = (state == DACC) & dWEN;
        ramaddr = (state == IACC) ? iaddr : (state == DACC) ? daddr : '0;
        ramstore = (state == DACC) ? dstore : '0;
        iready = (state == IACC) & done;
        dready = (state == DACC) & done;
        iload = iready ? ramload : iload_q;
        dload = dready ? ramload : dload_q;
        timeout_err = tmo;
        next = state;
        streak_n = streak;
        if (state == IDLE) begin
            if (!iREN) streak_n = '0;
            // data wins unless fetch has already lost DSTREAK_MAX times in a row
            if ((dREN | dWEN) && !(iREN && streak == SMAX)) next = DACC;
            else if (iREN) next = IACC;
        end else if (done | tmo | ~req) begin
            next = IDLE;
            if (iready) streak_n = '0;
            if (dready && iREN && streak != SMAX) streak_n = streak + 4'd1;
        end
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            streak  <= '0;
            wdog    <= '0;
            iload_q <= '0;
            dload_q <= '0;
        end else begin
            state   <= next;
            streak  <= streak_n;
            // every access is entered from IDLE, so holding zero there clears it on entry
            wdog    <= (state == IDLE) ? 8'd0 : wdog + 8'd1;
            iload_q <= iload;
            dload_q <= dload;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench with a per-cycle ownership model of the arbiter
module tb_mem_arbiter;
    localparam int DMAX = 4;
    localparam int TMO = 8;
    logic CLK = 1'b0, nRST;
    logic iREN, dREN, dWEN, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic ramREN, ramWEN, iready, dready, timeout_err;
    logic [31:0] ramaddr, ramstore, iload, dload;
    int checks = 0, errors = 0;
    int n_i = 0, n_d = 0, n_t = 0;
    int own, waited, dwins;
    logic [31:0] m_iload, m_dload, e_addr, e_store;
    logic [4:0] e_ctl;
    logic active, fin, abort;
    int bi, bd, bt, found, at;

    mem_arbiter #(.DSTREAK_MAX(DMAX), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ram_ready(ram_ready), .ramload(ramload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .iready(iready), .dready(dready), .iload(iload), .dload(dload),
        .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic look();
        @(negedge CLK);
    endtask

    // Model: own = 0 none, 1 fetch, 2 data; waited = cycles spent in the current access;
    // dwins = data completions in a row while fetch was waiting.
    always @(negedge CLK) begin
        if (!nRST) begin
            own = 0; waited = 0; dwins = 0;
            m_iload = '0; m_dload = '0;
            e_ctl = '0; e_addr = '0; e_store = '0;
        end else begin
            active = (own == 1 && iREN) || (own == 2 && (dREN || dWEN));
            fin = active && ram_ready;
            abort = active && !ram_ready && waited == TMO - 1;
            e_ctl = {(own == 1 && iREN) || (own == 2 && dREN && !dWEN), own == 2 && dWEN,
                     own == 1 && fin, own == 2 && fin, abort};
            e_addr = own == 1 ? iaddr : own == 2 ? daddr : 32'h0;
            e_store = own == 2 ? dstore : 32'h0;
            if (own == 1 && fin) m_iload = ramload;
            if (own == 2 && fin) m_dload = ramload;
        end
        chk("ctl{ren,wen,irdy,drdy,tmo}", {27'h0, ramREN, ramWEN, iready, dready, timeout_err}, {27'h0, e_ctl});
        chk("ramaddr", ramaddr, e_addr);
        chk("ramstore", ramstore, e_store);
        chk("iload", iload, m_iload);
        chk("dload", dload, m_dload);
        if (nRST) begin
            n_i += int'(iready); n_d += int'(dready); n_t += int'(timeout_err);
            if (own == 0) begin
                if (!iREN) dwins = 0;
                if ((dREN || dWEN) && !(iREN && dwins == DMAX)) own = 2;
                else if (iREN) own = 1;
                waited = 0;
            end else if (fin || abort || !active) begin
                if (own == 1 && fin) dwins = 0;
                if (own == 2 && fin && iREN) dwins = dwins < DMAX ? dwins + 1 : DMAX;
                own = 0;
            end else waited++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=hang want=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
        tick(); look();
        chk("rst_ramREN", {31'h0, ramREN}, 0);
        chk("rst_iload", iload, 0);
        tick(); nRST = 1'b1;
        tick();
        // lone fetch
        bi = n_i; bd = n_d;
        iREN = 1; iaddr = 32'h40;
        tick(); look();
        chk("fetch_ramREN", {31'h0, ramREN}, 1);
        chk("fetch_ramaddr", ramaddr, 32'h40);
        tick(); ram_ready = 1; ramload = 32'h2402000A; look();
        chk("fetch_iready", {31'h0, iready}, 1);
        tick(); iREN = 0; ram_ready = 0; ramload = '0; look();
        chk("fetch_iload", iload, 32'h2402000A);
        chk("fetch_ipulses", n_i - bi, 1);
        chk("fetch_dpulses", n_d - bd, 0);
        // simultaneous requests: data first, idle gap, then fetch
        iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF;
        tick(); ram_ready = 1; look();
        chk("sim_ramWEN", {31'h0, ramWEN}, 1);
        chk("sim_ramstore", ramstore, 32'hDEADBEEF);
        chk("sim_dready", {31'h0, dready}, 1);
        tick(); dWEN = 0; ram_ready = 0; look();
        chk("sim_gap_ramREN", {31'h0, ramREN}, 0);
        tick(); ram_ready = 1; look();
        chk("sim_iaddr", ramaddr, 32'h44);
        chk("sim_iready", {31'h0, iready}, 1);
        tick(); iREN = 0; ram_ready = 0;
        // starvation guard
        bd = n_d; found = 0;
        iREN = 1; iaddr = 32'h48; dREN = 1; daddr = 32'h90; ram_ready = 1; ramload = 32'h55;
        for (int k = 0; k < 20 && found == 0; k++) begin
            tick(); look();
            if (iready) found = 1;
        end
        chk("starve_iacc_granted", found, 1);
        chk("starve_dpulses", n_d - bd, 4);
        tick(); look();
        tick(); look();
        chk("starve_streak_cleared", {31'h0, dready}, 1);
        tick(); iREN = 0; dREN = 0; ram_ready = 0; ramload = '0;
        tick();
        // watchdog
        bd = n_d; bt = n_t; at = 0;
        dREN = 1; daddr = 32'h100;
        for (int k = 1; k <= 12 && at == 0; k++) begin
            tick(); look();
            if (timeout_err) at = k;
        end
        tick(); dREN = 0; look();
        chk("tmo_cycle", at, TMO);
        chk("tmo_pulses", n_t - bt, 1);
        chk("tmo_no_dready", n_d - bd, 0);
        chk("tmo_idle_ramREN", {31'h0, ramREN}, 0);
        // withdrawal
        bi = n_i;
        iREN = 1; iaddr = 32'h200;
        tick(); look();
        chk("wd_ramREN_on", {31'h0, ramREN}, 1);
        tick(); iREN = 0; look();
        chk("wd_ramREN_off", {31'h0, ramREN}, 0);
        tick(); iREN = 1; iaddr = 32'h204; ram_ready = 1; look();
        chk("wd_idle_ignores_ready", {31'h0, iready}, 0);
        tick(); look();
        chk("wd_regrant_addr", ramaddr, 32'h204);
        tick(); iREN = 0; ram_ready = 0; look();
        chk("wd_ipulses", n_i - bi, 1);
        // reset in the middle of a write
        dREN = 1; daddr = 32'h300;
        tick(); ram_ready = 1; ramload = 32'h12345678;
        tick(); dREN = 0; ram_ready = 0; ramload = '0;
        dWEN = 1; daddr = 32'h304; dstore = 32'hCAFEF00D;
        tick(); #2;
        chk("mid_ramWEN", {31'h0, ramWEN}, 1);
        chk("mid_dload", dload, 32'h12345678);
        nRST = 1'b0; #1;
        chk("arst_ramWEN", {31'h0, ramWEN}, 0);
        chk("arst_dload", dload, 0);
        tick(); dWEN = 0;
        tick(); nRST = 1'b1;
        iREN = 1; dREN = 1; daddr = 32'h308; ram_ready = 1; ramload = 32'h77;
        tick(); look();
        chk("post_rst_data_wins", {31'h0, dready}, 1);
        tick(); iREN = 0; dREN = 0; ram_ready = 0; ramload = '0;
        tick(); look();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
